// File: rtl/memory_responder.sv
// Word-organised unified memory that answers fetch, load and store requests.
// Each accepted request is held for LATENCY wait states, then one response.
module memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        request_valid,
  input  logic        request_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enable,
  output logic        request_ready,
  output logic        response_valid,
  output logic [31:0] read_data,
  output logic        fault
);

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        commit;
  logic        accept;

  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_be;
  logic        bad;

  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           mem [DEPTH];

  assign request_ready = (state != WAIT);
  assign accept        = request_valid && request_ready;
  assign idx           = req_addr[ADDR_WIDTH+1:2];
  assign bad           = (req_addr[1:0] != 2'b00) ||
                         (req_addr[31:ADDR_WIDTH+2] != '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      IDLE, RESPOND: begin
        if (accept) begin
          state_nxt = WAIT;
          cnt_nxt   = LAT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        // counter counts down to zero so LATENCY = 15 never wraps
        if (cnt == 4'd0) begin
          state_nxt = RESPOND;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_write <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      req_be    <= '0;
    end else if (accept) begin
      req_write <= request_write;
      req_addr  <= address;
      req_data  <= write_data;
      req_be    <= byte_enable;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      response_valid <= 1'b0;
      read_data      <= '0;
      fault          <= 1'b0;
    end else begin
      response_valid <= commit;
      fault          <= commit && bad;
      if (commit && !req_write && !bad) begin
        read_data <= mem[idx];
      end else begin
        read_data <= '0;
      end
    end
  end

  // storage array is deliberately not reset
  always_ff @(posedge clock) begin
    if (commit && req_write && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) begin
          mem[idx][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: four instances at LATENCY 2, 0, 3, 15.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       rst_n;
  logic [3:0]       rv;
  logic             wr;
  logic [31:0]      addr;
  logic [31:0]      wd;
  logic [3:0]       be;
  logic [3:0]       rdy;
  logic [3:0]       rsp;
  logic [3:0]       flt;
  logic [3:0][31:0] rd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        flt;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int L = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 3 : 15;
    memory_responder #(
      .ADDR_WIDTH(10),
      .LATENCY   (L)
    ) u_dut (
      .clock         (clk),
      .reset_n       (rst_n[g]),
      .request_valid (rv[g]),
      .request_write (wr),
      .address       (addr),
      .write_data    (wd),
      .byte_enable   (be),
      .request_ready (rdy[g]),
      .response_valid(rsp[g]),
      .read_data     (rd[g]),
      .fault         (flt[g])
    );
  end

  function automatic int lat(int i);
    case (i)
      0: return 2;
      1: return 0;
      2: return 3;
      default: return 15;
    endcase
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rsp[i]) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp inst=%0d actual=1 required=0", i);
        end else begin
          e = q.pop_front();
          check("resp_inst", i, e.inst);
          check("resp_data", rd[i], e.data);
          check("resp_fault", {31'd0, flt[i]}, {31'd0, e.flt});
          check("resp_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL resp_timeout actual=%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic do_req(int i, bit w, logic [31:0] a, logic [31:0] d,
                        logic [3:0] b, logic [31:0] ed, bit ef);
    int n = 0;
    int acc;
    @(negedge clk);
    wr    = w;
    addr  = a;
    wd    = d;
    be    = b;
    rv[i] = 1'b1;
    while (!rdy[i] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) begin
      total++;
      bad++;
      $display("FAIL ready_timeout actual=0 required=1");
      rv[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    q.push_back('{inst: i, data: ed, flt: ef, due: acc + 1 + lat(i)});
    rv[i] = 1'b0;
    wr    = ~w;
    addr  = 32'hFFFF_FFFC;
    wd    = ~d;
    be    = ~b;
    drain();
  endtask

  task automatic abort(int i, int cycles);
    @(negedge clk);
    wr    = 1'b1;
    addr  = 32'h20;
    wd    = 32'hCAFE_F00D;
    be    = 4'hF;
    rv[i] = 1'b1;
    check("abort_ready_idle", {31'd0, rdy[i]}, 32'd1);
    @(posedge clk);
    #1;
    rv[i] = 1'b0;
    repeat (cycles) @(negedge clk);
    check("abort_ready_wait", {31'd0, rdy[i]}, 32'd0);
    #1;
    rst_n[i] = 1'b0;
    #1;
    check("abort_ready_reset", {31'd0, rdy[i]}, 32'd1);
    check("abort_resp_reset", {31'd0, rsp[i]}, 32'd0);
    #1;
    rst_n[i] = 1'b1;
    repeat (lat(i) + 4) @(negedge clk);
  endtask

  initial begin
    rst_n = 4'h0;
    rv    = 4'h0;
    wr    = 1'b0;
    addr  = '0;
    wd    = '0;
    be    = '0;
    #3;
    check("rst_ready", {28'd0, rdy}, 32'hF);
    check("rst_valid", {28'd0, rsp}, 32'h0);
    check("rst_fault", {28'd0, flt}, 32'h0);
    for (int i = 0; i < 4; i++) check("rst_rdata", rd[i], 32'h0);
    @(negedge clk);
    rst_n = 4'hF;

    do_req(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    do_req(0, 1, 32'h10, 32'h0000_1234, 4'h3, 32'h0, 0);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_1234, 0);
    do_req(0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 0);
    do_req(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEAD_1234, 0);
    do_req(0, 0, 32'h12, 32'h0, 4'h0, 32'h0, 1);
    do_req(0, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 1);
    do_req(0, 1, 32'h1010, 32'hAAAA_AAAA, 4'hF, 32'h0, 1);
    do_req(0, 1, 32'h13, 32'h5555_5555, 4'hF, 32'h0, 1);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_1234, 0);

    do_req(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
    @(negedge clk);
    wr    = 1'b0;
    addr  = 32'h10;
    be    = 4'h0;
    rv[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      check("held_ready", {31'd0, rdy[1]}, (j % 2 == 0) ? 32'd1 : 32'd0);
      if (rdy[1]) begin
        q.push_back('{inst: 1, data: 32'hDEAD_BEEF, flt: 1'b0, due: cyc + 2});
      end
      @(negedge clk);
    end
    rv[1] = 1'b0;
    drain();

    do_req(2, 1, 32'h20, 32'h1111_1111, 4'hF, 32'h0, 0);
    abort(2, 2);
    do_req(2, 0, 32'h20, 32'h0, 4'h0, 32'h1111_1111, 0);

    do_req(3, 1, 32'h20, 32'h2222_2222, 4'hF, 32'h0, 0);
    abort(3, 10);
    do_req(3, 0, 32'h20, 32'h0, 4'h0, 32'h2222_2222, 0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
